word_assembler: RTL and testbench
=================================

WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 The block SHALL have parameter NB_BYTE, default 8, meaning width of one received byte.
REQ-002 The block SHALL have parameter N_BYTES, default 4, meaning bytes per word (legal range 2..8).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first byte lands in the top byte lane, 0 = first byte lands in lane 0.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning idle cycles allowed between bytes of one word (0 = timeout disabled).
REQ-005 The block SHALL have port i_clk  in  1  clock, with one clock domain and all logic on the rising edge.
REQ-006 The block SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port i_rx_done  in  1  byte strobe, where every cycle sampled high accepts one byte.
REQ-008 The block SHALL have port i_data  in  NB_BYTE  byte value, valid when i_rx_done=1.
REQ-009 The block SHALL have port i_flush  in  1  discard the partial word and clear o_overrun.
REQ-010 The block SHALL have port i_ready  in  1  consumer accepts o_word.
REQ-011 The block SHALL have port o_word  out  NB_BYTE*N_BYTES  assembled word, held stable while o_valid=1.
REQ-012 The block SHALL have port o_valid  out  1  o_word holds an unconsumed word.
REQ-013 The block SHALL have port o_byte_cnt  out  clog2(N_BYTES+1)  bytes in the partial word.
REQ-014 The block SHALL have port o_timeout  out  1  one-cycle pulse when a partial word is discarded by timeout.
REQ-015 The block SHALL have port o_overrun  out  1  sticky flag set when a completed word is dropped.

Function
REQ-016 The assembly FSM SHALL have states IDLE (cnt=0) and FILL (0<cnt<N_BYTES); the output register SHALL be separate (double buffer), so assembly continues while o_valid=1.
REQ-017 On each i_rx_done=1 cycle the block SHALL write i_data into lane (MSB_FIRST ? N_BYTES-1-cnt : cnt) and increment cnt; IDLE->FILL on the first byte.
REQ-018 On the N_BYTES-th byte, the complete word SHALL be copied to o_word and o_valid set at that same clock edge (zero added latency), with cnt returning to 0 and the FSM to IDLE.
REQ-019 A transfer SHALL occur when o_valid=1 and i_ready=1; o_valid SHALL clear on the next edge unless a new word completes in that same cycle, in which case o_word is reloaded and o_valid stays 1.
REQ-020 If a word completes while o_valid=1 and i_ready=0, the new word SHALL be dropped, o_word kept unchanged, and o_overrun set until i_flush or reset.
REQ-021 In FILL, an idle counter SHALL count cycles without i_rx_done; on reaching TIMEOUT_CYC the partial word SHALL be discarded, cnt=0, state IDLE, and o_timeout pulsed for 1 cycle. Any byte SHALL reset the idle counter. The idle counter SHALL not run in IDLE or when TIMEOUT_CYC=0.
REQ-022 i_flush=1 SHALL set cnt=0, state IDLE, clear o_overrun, and leave o_word/o_valid untouched; a byte arriving in the same cycle as i_flush SHALL be ignored.
REQ-023 A byte arriving in the cycle the timeout fires SHALL take priority: it is accepted and no timeout is reported.
REQ-024 Unwritten lanes of the partial word SHALL not be observable on o_word.

Reset
REQ-025 When i_reset=1 at a clock edge, the block SHALL set o_word=0, o_valid=0, o_byte_cnt=0, o_timeout=0, o_overrun=0, idle counter=0, and state IDLE, overriding all other inputs including mid-word and pending-output conditions.

Verification
REQ-026 The bench SHALL cover defaults: bytes FF,00,FF,00 on 4 consecutive strobe cycles with i_ready=0 -> o_word=FF00FF00, o_valid=1 at the 4th edge, o_overrun=0.
REQ-027 The bench SHALL cover MSB_FIRST=0: bytes 11,22,33,44 -> o_word=44332211; with i_rx_done=0 and i_data=F0 afterwards, o_word is unchanged.
REQ-028 The bench SHALL cover overrun: word A is pending with i_ready=0 and word B completes -> o_word=A and o_overrun=1; after i_ready=1 for 1 cycle, o_valid=0 and o_overrun stays 1; after i_flush, o_overrun=0.
REQ-029 The bench SHALL cover timeout: with TIMEOUT_CYC=10, 2 bytes then silence -> o_timeout pulses exactly once, 10 cycles after the 2nd byte, with o_byte_cnt=0; the next 4 bytes form a correct word.
REQ-030 The bench SHALL cover simultaneous transfer and completion: i_ready=1 in the cycle the next word completes -> o_valid stays 1, o_word becomes the new word, and o_overrun=0.
REQ-031 The bench SHALL cover reset mid-word: after 3 bytes, i_reset for 1 cycle -> all outputs are 0; the next 4 bytes form a word with no residue from before reset.

Source files
------------

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into N_BYTES-wide words behind a one-deep output register.
module word_assembler #(
    parameter int NB_BYTE     = 8,
    parameter int N_BYTES     = 4,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_rx_done,
    input  logic [NB_BYTE-1:0]           i_data,
    input  logic                         i_flush,
    input  logic                         i_ready,
    output logic [NB_BYTE*N_BYTES-1:0]   o_word,
    output logic                         o_valid,
    output logic [$clog2(N_BYTES+1)-1:0] o_byte_cnt,
    output logic                         o_timeout,
    output logic                         o_overrun
);
    localparam int W  = NB_BYTE * N_BYTES;
    localparam int CW = $clog2(N_BYTES + 1);
    localparam int IW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N_BYTES - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, lane;
    logic [IW-1:0] idle_q, idle_d;
    logic [W-1:0]  asm_q, asm_d, word_q, word_d;
    logic          valid_q, valid_d, timeout_q, timeout_d, overrun_q, overrun_d;
    logic          byte_ok, done, expire, load;

    always_comb begin
        byte_ok = i_rx_done && !i_flush;
        done    = byte_ok && cnt_q == CNT_LAST;
        // a byte in the expiry cycle wins, so expiry requires an idle cycle
        expire  = TIMEOUT_CYC != 0 && state_q == FILL && !i_rx_done && !i_flush && idle_q == IDLE_LAST;
        lane    = MSB_FIRST != 0 ? CNT_LAST - cnt_q : cnt_q;
        asm_d   = asm_q;
        for (int i = 0; i < N_BYTES; i++)
            if (byte_ok && CW'(i) == lane) asm_d[i*NB_BYTE +: NB_BYTE] = i_data;
        cnt_d     = (i_flush || done || expire) ? '0 : byte_ok ? cnt_q + 1'b1 : cnt_q;
        state_d   = cnt_d == '0 ? IDLE : FILL;
        idle_d    = (TIMEOUT_CYC == 0 || state_q == IDLE || i_rx_done || i_flush || expire) ? '0 : idle_q + 1'b1;
        timeout_d = expire;
        load      = done && (!valid_q || i_ready);
        word_d    = load ? asm_d : word_q;
        valid_d   = load || (valid_q && !i_ready);
        overrun_d = !i_flush && (overrun_q || (done && valid_q && !i_ready));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            asm_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            asm_q     <= asm_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_word     = word_q;
    assign o_valid    = valid_q;
    assign o_byte_cnt = cnt_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;
endmodule

// File: tb/tb_word_assembler.sv
// tb_word_assembler: two configurations driven in lockstep, checked against a byte-level model and a word scoreboard.
module tb_word_assembler;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst = 1, rx = 0, fl = 0, rdy = 0;
    logic [7:0]  dat = 0;
    logic [31:0] w0, w1;
    logic        v0, v1, t0, t1, o0, o1;
    logic [2:0]  c0, c1;

    word_assembler #(.TIMEOUT_CYC(10)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_rx_done(rx), .i_data(dat), .i_flush(fl), .i_ready(rdy),
        .o_word(w0), .o_valid(v0), .o_byte_cnt(c0), .o_timeout(t0), .o_overrun(o0));
    word_assembler #(.MSB_FIRST(0), .TIMEOUT_CYC(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_rx_done(rx), .i_data(dat), .i_flush(fl), .i_ready(rdy),
        .o_word(w1), .o_valid(v1), .o_byte_cnt(c1), .o_timeout(t1), .o_overrun(o1));

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: bytes kept in arrival order, placed into lanes only when a word completes
    int          msb[2] = '{1, 0};
    int          tmo[2] = '{10, 0};
    logic [7:0]  pb[2][4];
    int          pc[2], idl[2];
    logic        mv[2], mto[2], mov[2], pv[2];
    logic [31:0] mw[2];
    logic        lrdy;
    logic [31:0] q0[$], q1[$];

    function automatic logic [31:0] assemble(input int k);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[(msb[k] != 0 ? 3 - i : i)*8 +: 8] = pb[k][i];
        return r;
    endfunction

    task automatic step(input int k);
        logic xfer;
        xfer = mv[k] && rdy;
        if (rst) begin
            pc[k] = 0; idl[k] = 0; mv[k] = 0; mto[k] = 0; mov[k] = 0; mw[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            mto[k] = 0;
            if (fl) begin
                pc[k] = 0; idl[k] = 0; mov[k] = 0;
                if (xfer) mv[k] = 0;
            end else if (rx) begin
                pb[k][pc[k]] = dat;
                pc[k]++;
                idl[k] = 0;
                if (pc[k] == 4) begin
                    pc[k] = 0;
                    if (!mv[k] || rdy) begin
                        mw[k] = assemble(k);
                        mv[k] = 1;
                        if (k == 0) q0.push_back(mw[k]); else q1.push_back(mw[k]);
                    end else mov[k] = 1;
                end else if (xfer) mv[k] = 0;
            end else begin
                if (xfer) mv[k] = 0;
                if (pc[k] > 0 && tmo[k] > 0) begin
                    idl[k]++;
                    if (idl[k] == tmo[k]) begin
                        pc[k] = 0; idl[k] = 0; mto[k] = 1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        step(0);
        step(1);
        lrdy = rdy;
    end

    task automatic mon(input int k, input logic [31:0] w, input logic v, input logic [2:0] c,
                       input logic t, input logic o);
        logic [31:0] e;
        chk($sformatf("valid%0d", k), v, mv[k]);
        chk($sformatf("word%0d", k), w, mw[k]);
        chk($sformatf("cnt%0d", k), c, pc[k]);
        chk($sformatf("timeout%0d", k), t, mto[k]);
        chk($sformatf("overrun%0d", k), o, mov[k]);
        // a fresh word is presented when valid rises or reloads right after a transfer
        if (v && (!pv[k] || lrdy)) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("sb_unexpected%0d", k), w, 32'hx);
            else begin
                e = k == 0 ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sb_word%0d", k), w, e);
            end
        end
        pv[k] = v;
    endtask

    initial begin pv[0] = 0; pv[1] = 0; end

    always @(negedge clk) begin
        mon(0, w0, v0, c0, t0, o0);
        mon(1, w1, v1, c1, t1, o1);
    end

    task automatic cyc(input logic r, input logic [7:0] d, input logic f, input logic y, input logic s);
        rx = r; dat = d; fl = f; rdy = y; rst = s;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic y);
        cyc(1, d, 0, y, 0);
    endtask

    int pulses;

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_word", w0, 0); chk("rst_valid", v0, 0); chk("rst_cnt", c0, 0);
        chk("rst_to", t0, 0); chk("rst_ovr", o0, 0);

        send(8'hFF, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h00, 0);
        chk("msb_word", w0, 32'hFF00FF00); chk("msb_valid", v0, 1); chk("msb_ovr", o0, 0);
        chk("lsb_word", w1, 32'h00FF00FF);

        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        chk("ovr_word", w0, 32'hFF00FF00); chk("ovr_flag", o0, 1); chk("ovr_valid", v0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovr_drain", v0, 0); chk("ovr_sticky", o0, 1);
        cyc(0, 0, 1, 0, 0);
        chk("ovr_flush0", o0, 0); chk("ovr_flush1", o1, 0);

        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("lsb_word2", w1, 32'h44332211); chk("msb_word2", w0, 32'h11223344);
        cyc(0, 8'hF0, 0, 0, 0);
        chk("lsb_hold", w1, 32'h44332211);

        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 1);
        chk("sim_valid", v0, 1); chk("sim_word", w0, 32'hA1B2C3D4); chk("sim_ovr", o0, 0);
        chk("sim_word1", w1, 32'hD4C3B2A1);
        cyc(0, 0, 0, 1, 0);
        chk("sim_drain", v0, 0);

        send(8'h55, 0); send(8'h66, 0);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (t0) pulses++;
            chk($sformatf("to_pulse_%0d", i), t0, 32'(i == 10));
            if (i == 10) chk("to_cnt", c0, 0);
        end
        chk("to_once", pulses, 1);
        chk("to_disabled_cnt", c1, 2);
        send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 0);
        chk("to_word", w0, 32'h9ABCDEF0); chk("to_word1", w1, 32'hBC9A6655);
        cyc(0, 0, 1, 1, 0);

        send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        cyc(0, 0, 0, 0, 1);
        chk("mid_rst_word", w0, 0); chk("mid_rst_valid", v0, 0); chk("mid_rst_cnt", c0, 0);
        chk("mid_rst_to", t0, 0); chk("mid_rst_ovr", o0, 0); chk("mid_rst_word1", w1, 0);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        chk("post_rst_word", w0, 32'h12345678); chk("post_rst_word1", w1, 32'h78563412);

        for (int n = 0; n < 2400; n++)
            cyc($urandom_range(99) < (n < 1200 ? 60 : 12), 8'($urandom), $urandom_range(99) < 2,
                1'($urandom_range(1)), $urandom_range(299) == 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("sb_drained", q0.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
